// File: rtl/friscv_cache_rd_arbiter_if.sv
// AXI4 read address + read data channel bundle shared by the cache fetchers
// and the memory controller port of the read arbiter.
interface friscv_cache_rd_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int ID_W   = 8,
  parameter int DATA_W = 32
);
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arprot;
  logic [ID_W-1:0]   arid;
  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic [ID_W-1:0]   rid;

  modport master (
    output arvalid, araddr, arprot, arid, rready,
    input  arready, rvalid, rdata, rresp, rid
  );

  modport slave (
    input  arvalid, araddr, arprot, arid, rready,
    output arready, rvalid, rdata, rresp, rid
  );
endinterface

// File: rtl/friscv_cache_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4 read channel between the instruction
// and data cache line fetchers, with in-order completion routing.
module friscv_cache_rd_arbiter #(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_ID_W   = 8,
  parameter int AXI_DATA_W = 32,
  parameter int MAX_OSTDG  = 4
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic                      srst,
  friscv_cache_rd_arbiter_if.slave  req0,
  friscv_cache_rd_arbiter_if.slave  req1,
  friscv_cache_rd_arbiter_if.master memctrl
);

  localparam int CW    = $clog2(MAX_OSTDG) + 1;
  localparam int DEPTH = 2 * MAX_OSTDG;
  localparam int PW    = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OSTDG);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t                state;
  logic                  arvalid_q;
  logic [AXI_ADDR_W-1:0] araddr_q;
  logic [2:0]            arprot_q;
  logic [AXI_ID_W-1:0]   arid_q;
  logic                  prio;
  logic [CW-1:0]         cnt0;
  logic [CW-1:0]         cnt1;
  logic [DEPTH-1:0]      order_q;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  head;
  logic                  elig0;
  logic                  elig1;
  logic                  grant0;
  logic                  grant1;
  logic                  rd_hs;
  logic                  pop0;
  logic                  pop1;
  logic [AXI_DATA_W-1:0] rdata_bc;
  logic [AXI_ID_W-1:0]   rid_bc;

  // Extra wrap bit on the pointers distinguishes full from empty.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                      (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
  assign head       = order_q[rd_ptr[PW-2:0]];

  // Grants are suppressed while either reset is active so a request is never
  // acknowledged and then dropped.
  assign elig0  = aresetn && !srst && (state == IDLE) && req0.arvalid &&
                  (cnt0 < MAX_CNT) && !fifo_full;
  assign elig1  = aresetn && !srst && (state == IDLE) && req1.arvalid &&
                  (cnt1 < MAX_CNT) && !fifo_full;
  assign grant0 = elig0 && (!elig1 || !prio);
  assign grant1 = elig1 && (!elig0 || prio);

  assign req0.arready = grant0;
  assign req1.arready = grant1;

  assign memctrl.arvalid = arvalid_q;
  assign memctrl.araddr  = araddr_q;
  assign memctrl.arprot  = arprot_q;
  assign memctrl.arid    = arid_q;

  assign req0.rvalid    = !fifo_empty && !head && memctrl.rvalid;
  assign req1.rvalid    = !fifo_empty &&  head && memctrl.rvalid;
  assign memctrl.rready = !fifo_empty && (head ? req1.rready : req0.rready);

  assign rdata_bc   = memctrl.rdata;
  assign rid_bc     = memctrl.rid;
  assign req0.rdata = rdata_bc;
  assign req1.rdata = rdata_bc;
  assign req0.rresp = memctrl.rresp;
  assign req1.rresp = memctrl.rresp;
  assign req0.rid   = rid_bc;
  assign req1.rid   = rid_bc;

  assign rd_hs = memctrl.rvalid && memctrl.rready;
  assign pop0  = rd_hs && !head;
  assign pop1  = rd_hs &&  head;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= IDLE;
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      arprot_q  <= '0;
      arid_q    <= '0;
      prio      <= 1'b0;
      cnt0      <= '0;
      cnt1      <= '0;
      order_q   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else if (srst) begin
      state     <= IDLE;
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      arprot_q  <= '0;
      arid_q    <= '0;
      prio      <= 1'b0;
      cnt0      <= '0;
      cnt1      <= '0;
      order_q   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            state     <= ISSUE;
            arvalid_q <= 1'b1;
            araddr_q  <= grant1 ? req1.araddr : req0.araddr;
            arprot_q  <= grant1 ? req1.arprot : req0.arprot;
            arid_q    <= grant1 ? req1.arid   : req0.arid;
            prio      <= grant0;
            order_q[wr_ptr[PW-2:0]] <= grant1;
            wr_ptr    <= wr_ptr + PW'(1);
          end
        end
        ISSUE: begin
          if (memctrl.arready) begin
            state     <= IDLE;
            arvalid_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      if (rd_hs) begin
        rd_ptr <= rd_ptr + PW'(1);
      end

      // A grant and a completion on the same requester cancel out.
      cnt0 <= cnt0 + CW'(grant0) - CW'(pop0);
      cnt1 <= cnt1 + CW'(grant1) - CW'(pop1);
    end
  end

endmodule

// File: tb/tb_friscv_cache_rd_arbiter.sv
// Directed self-checking bench for friscv_cache_rd_arbiter.
module tb_friscv_cache_rd_arbiter;

  localparam int AW = 32;
  localparam int IW = 8;
  localparam int DW = 32;
  localparam int MO = 4;

  logic aclk = 1'b0;
  logic aresetn;
  logic srst;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  always #5 aclk = ~aclk;

  friscv_cache_rd_arbiter_if #(.ADDR_W(AW), .ID_W(IW), .DATA_W(DW)) req0_if ();
  friscv_cache_rd_arbiter_if #(.ADDR_W(AW), .ID_W(IW), .DATA_W(DW)) req1_if ();
  friscv_cache_rd_arbiter_if #(.ADDR_W(AW), .ID_W(IW), .DATA_W(DW)) mem_if ();

  friscv_cache_rd_arbiter #(
    .AXI_ADDR_W (AW),
    .AXI_ID_W   (IW),
    .AXI_DATA_W (DW),
    .MAX_OSTDG  (MO)
  ) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .srst    (srst),
    .req0    (req0_if),
    .req1    (req1_if),
    .memctrl (mem_if)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    total_cnt++;
    assert (observed === expected) pass_cnt++;
    else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Outputs are sampled 2 time units after the rising edge, well clear of it.
  task automatic tick();
    @(posedge aclk);
    #2;
  endtask

  task automatic applyStimulus(input logic v0, input logic [AW-1:0] a0, input logic [IW-1:0] i0,
                               input logic v1, input logic [AW-1:0] a1, input logic [IW-1:0] i1);
    req0_if.arvalid = v0;
    req0_if.araddr  = a0;
    req0_if.arid    = i0;
    req0_if.arprot  = i0[2:0];
    req1_if.arvalid = v1;
    req1_if.araddr  = a1;
    req1_if.arid    = i1;
    req1_if.arprot  = i1[2:0];
    #1;
  endtask

  task automatic memDrive(input logic arready, input logic rvalid,
                          input logic [DW-1:0] rdata, input logic [IW-1:0] rid);
    mem_if.arready = arready;
    mem_if.rvalid  = rvalid;
    mem_if.rdata   = rdata;
    mem_if.rid     = rid;
    #1;
  endtask

  initial begin
    aresetn = 1'b0;
    srst    = 1'b0;
    req0_if.rready = 1'b1;
    req1_if.rready = 1'b1;
    mem_if.rresp   = 2'b00;
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    memDrive(1'b0, 1'b0, '0, '0);
    tick();
    tick();
    checkOutput("rst_arvalid", 64'(mem_if.arvalid), 64'd0);
    checkOutput("rst_araddr", 64'(mem_if.araddr), 64'd0);
    checkOutput("rst_mem_rready", 64'(mem_if.rready), 64'd0);
    aresetn = 1'b1;
    tick();

    // Single request from the instruction cache
    memDrive(1'b1, 1'b0, '0, '0);
    applyStimulus(1'b1, 32'h100, 8'd3, 1'b0, '0, '0);
    checkOutput("single_req0_arready", 64'(req0_if.arready), 64'd1);
    checkOutput("single_req1_arready", 64'(req1_if.arready), 64'd0);
    checkOutput("single_arvalid_T", 64'(mem_if.arvalid), 64'd0);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    checkOutput("single_arvalid_T1", 64'(mem_if.arvalid), 64'd1);
    checkOutput("single_araddr", 64'(mem_if.araddr), 64'h100);
    checkOutput("single_arid", 64'(mem_if.arid), 64'd3);
    checkOutput("single_arprot", 64'(mem_if.arprot), 64'd3);
    checkOutput("single_issue_arready", 64'(req0_if.arready), 64'd0);
    tick();
    checkOutput("single_arvalid_clr", 64'(mem_if.arvalid), 64'd0);
    mem_if.rresp = 2'b10;
    memDrive(1'b1, 1'b1, 32'hDEADBEEF, 8'd3);
    checkOutput("single_req0_rvalid", 64'(req0_if.rvalid), 64'd1);
    checkOutput("single_req1_rvalid", 64'(req1_if.rvalid), 64'd0);
    checkOutput("single_rdata", 64'(req0_if.rdata), 64'hDEADBEEF);
    checkOutput("single_rid", 64'(req0_if.rid), 64'd3);
    checkOutput("single_rresp", 64'(req0_if.rresp), 64'd2);
    checkOutput("single_mem_rready", 64'(mem_if.rready), 64'd1);
    tick();
    mem_if.rresp = 2'b00;

    // Unsolicited completion with an empty order FIFO
    memDrive(1'b1, 1'b1, 32'hBAD, 8'd9);
    checkOutput("unsol_mem_rready", 64'(mem_if.rready), 64'd0);
    checkOutput("unsol_req0_rvalid", 64'(req0_if.rvalid), 64'd0);
    checkOutput("unsol_req1_rvalid", 64'(req1_if.rvalid), 64'd0);
    memDrive(1'b1, 1'b0, '0, '0);

    // Contention: return the priority pointer to 0 first
    srst = 1'b1;
    tick();
    srst = 1'b0;
    applyStimulus(1'b1, 32'h200, 8'd10, 1'b1, 32'h300, 8'd20);
    for (int i = 0; i < 4; i++) begin
      checkOutput("cont_gnt_req0", 64'(req0_if.arready), 64'((i % 2) == 0));
      checkOutput("cont_gnt_req1", 64'(req1_if.arready), 64'((i % 2) == 1));
      tick();
      if (i == 3) applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
      checkOutput("cont_arvalid", 64'(mem_if.arvalid), 64'd1);
      checkOutput("cont_araddr", 64'(mem_if.araddr), ((i % 2) == 0) ? 64'h200 : 64'h300);
      checkOutput("cont_arid", 64'(mem_if.arid), ((i % 2) == 0) ? 64'd10 : 64'd20);
      checkOutput("cont_issue_arready0", 64'(req0_if.arready), 64'd0);
      checkOutput("cont_issue_arready1", 64'(req1_if.arready), 64'd0);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      memDrive(1'b1, 1'b1, 32'h1000 + 32'(i), 8'(i));
      checkOutput("cont_cpl_req0", 64'(req0_if.rvalid), 64'((i % 2) == 0));
      checkOutput("cont_cpl_req1", 64'(req1_if.rvalid), 64'((i % 2) == 1));
      checkOutput("cont_cpl_rready", 64'(mem_if.rready), 64'd1);
      tick();
    end
    memDrive(1'b1, 1'b0, '0, '0);

    // Outstanding limit on the instruction cache
    applyStimulus(1'b1, 32'h400, 8'd5, 1'b0, '0, '0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("lim_grant", 64'(req0_if.arready), 64'd1);
      tick();
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      checkOutput("lim_blocked", 64'(req0_if.arready), 64'd0);
      checkOutput("lim_idle_arvalid", 64'(mem_if.arvalid), 64'd0);
      tick();
    end
    memDrive(1'b1, 1'b1, 32'h55, 8'd5);
    checkOutput("lim_cpl_rvalid", 64'(req0_if.rvalid), 64'd1);
    checkOutput("lim_cpl_same_cycle", 64'(req0_if.arready), 64'd0);
    tick();
    memDrive(1'b1, 1'b0, '0, '0);
    checkOutput("lim_fifth_grant", 64'(req0_if.arready), 64'd1);
    tick();
    memDrive(1'b0, 1'b0, '0, '0);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);

    // Address backpressure
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_arvalid", 64'(mem_if.arvalid), 64'd1);
      checkOutput("bp_araddr", 64'(mem_if.araddr), 64'h400);
      checkOutput("bp_arid", 64'(mem_if.arid), 64'd5);
      checkOutput("bp_arprot", 64'(mem_if.arprot), 64'd5);
      tick();
    end
    memDrive(1'b1, 1'b0, '0, '0);
    tick();
    checkOutput("bp_arvalid_clr", 64'(mem_if.arvalid), 64'd0);

    // Completion backpressure
    req0_if.rready = 1'b0;
    memDrive(1'b0, 1'b1, 32'h66, 8'd5);
    checkOutput("rbp_mem_rready", 64'(mem_if.rready), 64'd0);
    checkOutput("rbp_req0_rvalid", 64'(req0_if.rvalid), 64'd1);
    tick();
    checkOutput("rbp_head_kept", 64'(req0_if.rvalid), 64'd1);
    checkOutput("rbp_req1_rvalid", 64'(req1_if.rvalid), 64'd0);
    checkOutput("rbp_mem_rready2", 64'(mem_if.rready), 64'd0);
    req0_if.rready = 1'b1;
    #1;
    checkOutput("rbp_release", 64'(mem_if.rready), 64'd1);
    tick();
    tick();
    memDrive(1'b0, 1'b0, '0, '0);

    // Data-cache request left in ISSUE with three reads outstanding
    applyStimulus(1'b0, '0, '0, 1'b1, 32'h500, 8'd7);
    checkOutput("pre_rst_req1_grant", 64'(req1_if.arready), 64'd1);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    checkOutput("pre_rst_arvalid", 64'(mem_if.arvalid), 64'd1);
    checkOutput("pre_rst_araddr", 64'(mem_if.araddr), 64'h500);

    aresetn = 1'b0;
    #1;
    checkOutput("arst_arvalid", 64'(mem_if.arvalid), 64'd0);
    checkOutput("arst_araddr", 64'(mem_if.araddr), 64'd0);
    checkOutput("arst_arid", 64'(mem_if.arid), 64'd0);
    checkOutput("arst_arprot", 64'(mem_if.arprot), 64'd0);
    memDrive(1'b0, 1'b1, 32'h77, 8'd1);
    checkOutput("arst_mem_rready", 64'(mem_if.rready), 64'd0);
    checkOutput("arst_req0_rvalid", 64'(req0_if.rvalid), 64'd0);
    checkOutput("arst_req1_rvalid", 64'(req1_if.rvalid), 64'd0);
    applyStimulus(1'b1, 32'h600, 8'd1, 1'b0, '0, '0);
    checkOutput("arst_req0_arready", 64'(req0_if.arready), 64'd0);
    tick();
    aresetn = 1'b1;
    #1;
    checkOutput("post_arst_fifo_empty", 64'(mem_if.rready), 64'd0);
    memDrive(1'b0, 1'b0, '0, '0);
    applyStimulus(1'b1, 32'h600, 8'd1, 1'b1, 32'h700, 8'd2);
    checkOutput("post_arst_prio0", 64'(req0_if.arready), 64'd1);
    checkOutput("post_arst_prio1", 64'(req1_if.arready), 64'd0);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    checkOutput("pre_srst_arvalid", 64'(mem_if.arvalid), 64'd1);
    checkOutput("pre_srst_araddr", 64'(mem_if.araddr), 64'h600);

    srst = 1'b1;
    #1;
    checkOutput("srst_is_sync", 64'(mem_if.arvalid), 64'd1);
    tick();
    checkOutput("srst_arvalid", 64'(mem_if.arvalid), 64'd0);
    checkOutput("srst_araddr", 64'(mem_if.araddr), 64'd0);
    checkOutput("srst_arid", 64'(mem_if.arid), 64'd0);
    memDrive(1'b0, 1'b1, 32'h88, 8'd1);
    checkOutput("srst_mem_rready", 64'(mem_if.rready), 64'd0);
    checkOutput("srst_req0_rvalid", 64'(req0_if.rvalid), 64'd0);
    applyStimulus(1'b1, 32'h800, 8'd1, 1'b0, '0, '0);
    checkOutput("srst_req0_arready", 64'(req0_if.arready), 64'd0);
    srst = 1'b0;
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    memDrive(1'b0, 1'b0, '0, '0);
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
